conv3x3_pe_array: RTL and testbench
===================================

CONV3X3_PE_ARRAY -- requirements
Module: conv3x3_pe_array

Interface
REQ-001 SHALL have parameter WIN_CNT, default 4096, windows processed per run (>=1).
REQ-002 SHALL have ports, one clock; reset is asynchronous and active-low:
- clk  input  1  single clock, rising edge
- rstn  input  1  asynchronous active-low reset
- i_start  input  1  run request, sampled in IDLE only
- o_load_en  output  1  kernel load request to the weight controller
- i_kernel_ready  input  1  weight controller ready; i_kernel0..11 valid while high
- i_kernel0 .. i_kernel11  input  72 each  3x3 kernels, 9 signed 8-bit weights, weight k at bits [8k+7:8k], row-major
- i_win_valid  input  1  window valid
- i_win  input  72  3x3 window, 9 unsigned 8-bit pixels, same byte order
- o_win_ready  output  1  window accepted when i_win_valid and o_win_ready are both high
- o_valid  output  1  o_psum valid, one-cycle qualifier
- o_psum  output  240  12 signed 20-bit sums, channel c at bits [20c+19:20c]
- o_busy  output  1  high in every state except IDLE
- o_done  output  1  one-cycle pulse at end of run

Function
REQ-003 SHALL implement FSM IDLE, WLOAD, RUN, DRAIN.
REQ-004 IDLE: i_start=1 -> WLOAD next cycle. i_start SHALL be ignored in all other states.
REQ-005 WLOAD: o_load_en=1 and held until i_kernel_ready=1. On the first cycle i_kernel_ready=1, all 12 kernels SHALL be captured into local registers and the FSM SHALL go to RUN. o_load_en=0 from the next cycle.
REQ-006 Local kernel registers SHALL be stable for the whole run. Later changes on i_kernel* SHALL be ignored.
REQ-007 RUN: o_win_ready=1. o_win_ready SHALL be 0 in all other states. Each accepted window SHALL increment a window counter.
REQ-008 When acceptance number WIN_CNT occurs, the FSM SHALL enter DRAIN next cycle and o_win_ready SHALL drop in that same next cycle. Further i_win_valid SHALL be ignored.
REQ-009 DRAIN: once the last accepted window's o_valid has issued, o_done SHALL pulse 1 cycle, the FSM SHALL return to IDLE, and the counter SHALL clear.
REQ-010 Per channel c, psum_c SHALL be the sum over k=0..8 of signed(w_c[k]) * unsigned(p[k]). Products SHALL be 17-bit signed. The sum SHALL be 20-bit signed, exact, with no saturation or truncation.
REQ-011 Pipeline SHALL be 3 stages: multiply, 3-way partial sums, final sum. A window accepted at edge t SHALL produce o_valid=1 with its o_psum after edge t+3.
REQ-012 Back-to-back acceptances SHALL yield back-to-back o_valid. Input gaps SHALL propagate as o_valid gaps. Results SHALL be in order.
REQ-013 There is no output backpressure. Consumers SHALL take o_psum on the o_valid cycle.
REQ-014 o_psum SHALL hold its last value when o_valid=0.
REQ-015 WIN_CNT=1 SHALL work: one acceptance, then DRAIN.

Reset
REQ-016 On rstn=0, at any time, these SHALL be asynchronous and immediate: FSM=IDLE, counter=0, pipeline valid bits=0, kernel registers=0.
REQ-017 Output reset values: o_load_en=0, o_win_ready=0, o_valid=0, o_psum=0, o_busy=0, o_done=0.
REQ-018 Reset mid-run SHALL discard in-flight windows. No o_valid or o_done SHALL follow until a new run.

Structure
REQ-019 A shared package SHALL hold PIX_W=8, WGT_W=8, TAPS=9, NUM_CH=12, PROD_W=17, PSUM_W=20, and the FSM state enumeration.
REQ-020 Sub-module pe_dot9 SHALL implement one channel's 3-stage dot product and SHALL be instantiated 12 times. Top level SHALL hold the FSM, counter, kernel registers and valid pipeline.

Verification
REQ-021 Reset: assert rstn=0 mid-RUN with 2 windows in flight -> all outputs 0 immediately; no o_valid afterward; i_start then runs normally.
REQ-022 Kernels all 0x01, window all 0xFF, WIN_CNT=1 -> every channel psum=2295 (0x008F7) exactly 3 cycles after acceptance; o_done one cycle later.
REQ-023 Kernels all 0x80, window all 0xFF -> each psum=-293760 (20-bit 0xB8480). Kernel c = c+1 in every byte, window all 0x01 -> psum_c = 9*(c+1).
REQ-024 i_kernel_ready held low 5 cycles after WLOAD entry -> o_load_en high 6 cycles, o_win_ready 0 throughout, kernel capture on the ready cycle only.
REQ-025 WIN_CNT=4, windows with 1-cycle gaps, 5th i_win_valid held high -> exactly 4 o_valid pulses matching the gap pattern; 5th window not accepted; o_done single pulse; o_busy falls with IDLE.
REQ-026 After capture, i_kernel0..11 changed to random values mid-RUN -> results still use the captured kernels.

Source files
------------

// File: rtl/conv3x3_pe_array_pkg.sv
// Shared widths and FSM states for the 3x3 convolution PE array.
package conv3x3_pe_array_pkg;

  localparam int PIX_W  = 8;
  localparam int WGT_W  = 8;
  localparam int TAPS   = 9;
  localparam int NUM_CH = 12;
  localparam int PROD_W = 17;
  localparam int PSUM_W = 20;
  localparam int VEC_W  = TAPS * PIX_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WLOAD = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/conv3x3_pe_array_pe_dot9.sv
// One output channel: 9-tap signed-weight x unsigned-pixel dot product, 3 register stages.
module pe_dot9
  import conv3x3_pe_array_pkg::*;
(
  input  logic                     clk,
  input  logic [VEC_W-1:0]         win,
  input  logic [VEC_W-1:0]         kernel,
  output logic signed [PSUM_W-1:0] psum
);

  logic signed [PROD_W-1:0] prod_p0 [TAPS];
  logic signed [PSUM_W-1:0] part_p1 [3];
  logic signed [PSUM_W-1:0] sum_p2;

  // Pixel is zero-extended so the product of an 8-bit signed and 8-bit unsigned fits 17 bits exactly.
  function automatic logic signed [PROD_W-1:0] mul_wp(input logic [WGT_W-1:0] w,
                                                     input logic [PIX_W-1:0] p);
    logic signed [PROD_W-1:0] ws;
    logic signed [PROD_W-1:0] ps;
    ws = PROD_W'($signed(w));
    ps = $signed(PROD_W'(p));
    return ws * ps;
  endfunction

  function automatic logic signed [PSUM_W-1:0] sext(input logic signed [PROD_W-1:0] v);
    return PSUM_W'(v);
  endfunction

  // Stage p0: multiply
  always_ff @(posedge clk) begin
    for (int k = 0; k < TAPS; k++) begin
      prod_p0[k] <= mul_wp(kernel[WGT_W*k +: WGT_W], win[PIX_W*k +: PIX_W]);
    end
  end

  // Stage p1: one partial sum per kernel row
  always_ff @(posedge clk) begin
    for (int r = 0; r < 3; r++) begin
      part_p1[r] <= sext(prod_p0[3*r]) + sext(prod_p0[3*r+1]) + sext(prod_p0[3*r+2]);
    end
  end

  // Stage p2: final sum
  always_ff @(posedge clk) begin
    sum_p2 <= part_p1[0] + part_p1[1] + part_p1[2];
  end

  assign psum = sum_p2;

endmodule

// File: rtl/conv3x3_pe_array.sv
// 12-channel 3x3 convolution array: kernel load handshake, window run control, valid pipeline.
module conv3x3_pe_array
  import conv3x3_pe_array_pkg::*;
#(
  parameter int WIN_CNT = 4096
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_start,
  output logic                      o_load_en,
  input  logic                      i_kernel_ready,
  input  logic [VEC_W-1:0]          i_kernel0,
  input  logic [VEC_W-1:0]          i_kernel1,
  input  logic [VEC_W-1:0]          i_kernel2,
  input  logic [VEC_W-1:0]          i_kernel3,
  input  logic [VEC_W-1:0]          i_kernel4,
  input  logic [VEC_W-1:0]          i_kernel5,
  input  logic [VEC_W-1:0]          i_kernel6,
  input  logic [VEC_W-1:0]          i_kernel7,
  input  logic [VEC_W-1:0]          i_kernel8,
  input  logic [VEC_W-1:0]          i_kernel9,
  input  logic [VEC_W-1:0]          i_kernel10,
  input  logic [VEC_W-1:0]          i_kernel11,
  input  logic                      i_win_valid,
  input  logic [VEC_W-1:0]          i_win,
  output logic                      o_win_ready,
  output logic                      o_valid,
  output logic [NUM_CH*PSUM_W-1:0]  o_psum,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int CNT_W = $clog2(WIN_CNT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_CNT - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         win_cnt;
  logic [VEC_W-1:0]         kern_in [NUM_CH];
  logic [VEC_W-1:0]         kern    [NUM_CH];
  logic signed [PSUM_W-1:0] psum_ch [NUM_CH];
  logic                     accept;
  logic                     drain_done;
  logic                     vld_p0;
  logic                     vld_p1;
  logic                     vld_p2;

  assign kern_in[0]  = i_kernel0;
  assign kern_in[1]  = i_kernel1;
  assign kern_in[2]  = i_kernel2;
  assign kern_in[3]  = i_kernel3;
  assign kern_in[4]  = i_kernel4;
  assign kern_in[5]  = i_kernel5;
  assign kern_in[6]  = i_kernel6;
  assign kern_in[7]  = i_kernel7;
  assign kern_in[8]  = i_kernel8;
  assign kern_in[9]  = i_kernel9;
  assign kern_in[10] = i_kernel10;
  assign kern_in[11] = i_kernel11;

  assign accept = i_win_valid & o_win_ready;
  // The last window is fully out once its o_valid is showing and nothing else is in flight.
  assign drain_done = (state == ST_DRAIN) && o_valid && !vld_p0 && !vld_p1 && !vld_p2;
  assign o_busy = (state != ST_IDLE);

  always_comb begin
    state_nxt   = state;
    o_load_en   = 1'b0;
    o_win_ready = 1'b0;
    case (state)
      ST_IDLE:  if (i_start) state_nxt = ST_WLOAD;
      ST_WLOAD: begin
        o_load_en = 1'b1;
        if (i_kernel_ready) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        o_win_ready = 1'b1;
        if (i_win_valid && (win_cnt == LAST_IDX)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (drain_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      win_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (drain_done) win_cnt <= '0;
      else if (accept) win_cnt <= win_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < NUM_CH; c++) kern[c] <= '0;
    end else if ((state == ST_WLOAD) && i_kernel_ready) begin
      for (int c = 0; c < NUM_CH; c++) kern[c] <= kern_in[c];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pe
    pe_dot9 u_pe (
      .clk    (clk),
      .win    (i_win),
      .kernel (kern[c]),
      .psum   (psum_ch[c])
    );
  end

  // Valid follows the three PE stages, then the output register that holds o_psum between results
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
      o_psum  <= '0;
    end else begin
      vld_p0  <= accept;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      o_valid <= vld_p2;
      o_done  <= drain_done;
      if (vld_p2) begin
        for (int c = 0; c < NUM_CH; c++) o_psum[PSUM_W*c +: PSUM_W] <= psum_ch[c];
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_pe_array.sv
// Directed-sequence bench with random data for conv3x3_pe_array, checked against an arithmetic model.
module tb_conv3x3_pe_array;

  localparam int WIN_A = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start_a = 1'b0;
  logic         start_b = 1'b0;
  logic         kernel_ready = 1'b0;
  logic         win_valid = 1'b0;
  logic [71:0]  win = '0;
  logic [71:0]  kin  [12];
  logic [71:0]  kref [12];

  logic         a_load_en, a_win_ready, a_valid, a_busy, a_done;
  logic [239:0] a_psum;
  logic         b_load_en, b_win_ready, b_valid, b_busy, b_done;
  logic [239:0] b_psum;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic [239:0] psum;
    int           cyc;
  } obs_t;

  obs_t mon_q[$];
  obs_t exp_q[$];
  int   done_a = 0;
  int   done_a_cyc = 0;
  logic done_a_busy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv3x3_pe_array #(.WIN_CNT(WIN_A)) dut_a (
    .clk(clk), .rstn(rstn), .i_start(start_a), .o_load_en(a_load_en),
    .i_kernel_ready(kernel_ready),
    .i_kernel0(kin[0]), .i_kernel1(kin[1]), .i_kernel2(kin[2]), .i_kernel3(kin[3]),
    .i_kernel4(kin[4]), .i_kernel5(kin[5]), .i_kernel6(kin[6]), .i_kernel7(kin[7]),
    .i_kernel8(kin[8]), .i_kernel9(kin[9]), .i_kernel10(kin[10]), .i_kernel11(kin[11]),
    .i_win_valid(win_valid), .i_win(win), .o_win_ready(a_win_ready),
    .o_valid(a_valid), .o_psum(a_psum), .o_busy(a_busy), .o_done(a_done)
  );

  conv3x3_pe_array #(.WIN_CNT(1)) dut_b (
    .clk(clk), .rstn(rstn), .i_start(start_b), .o_load_en(b_load_en),
    .i_kernel_ready(kernel_ready),
    .i_kernel0(kin[0]), .i_kernel1(kin[1]), .i_kernel2(kin[2]), .i_kernel3(kin[3]),
    .i_kernel4(kin[4]), .i_kernel5(kin[5]), .i_kernel6(kin[6]), .i_kernel7(kin[7]),
    .i_kernel8(kin[8]), .i_kernel9(kin[9]), .i_kernel10(kin[10]), .i_kernel11(kin[11]),
    .i_win_valid(win_valid), .i_win(win), .o_win_ready(b_win_ready),
    .o_valid(b_valid), .o_psum(b_psum), .o_busy(b_busy), .o_done(b_done)
  );

  always @(negedge clk) begin
    if (a_valid) mon_q.push_back('{a_psum, cyc});
    if (a_done) begin
      done_a++;
      done_a_cyc = cyc;
      done_a_busy = a_busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [239:0] obs, input logic [239:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] rand_vec();
    logic [95:0] v;
    v = {$urandom(), $urandom(), $urandom()};
    return v[71:0];
  endfunction

  function automatic logic [71:0] make_win(input int mode);
    if (mode == 1) return {9{8'hFF}};
    if (mode == 2) return {9{8'h01}};
    return rand_vec();
  endfunction

  // Sum over taps of signed weight times unsigned pixel, kept as a plain integer per channel.
  function automatic logic [239:0] ref_psum(input logic [71:0] w);
    logic [239:0] r;
    int s, wt, px;
    r = '0;
    for (int c = 0; c < 12; c++) begin
      s = 0;
      for (int t = 0; t < 9; t++) begin
        wt = int'($signed(kref[c][8*t +: 8]));
        px = int'(w[8*t +: 8]);
        s += wt * px;
      end
      r[20*c +: 20] = s[19:0];
    end
    return r;
  endfunction

  task automatic clear_a();
    mon_q.delete();
    exp_q.delete();
    done_a = 0;
  endtask

  task automatic load_a(input int delay);
    int lcnt;
    lcnt = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 0; i < delay; i++) begin
      for (int c = 0; c < 12; c++) kin[c] = rand_vec();
      chk("wload_win_ready", a_win_ready, 0);
      if (a_load_en) lcnt++;
      @(posedge clk); #1;
    end
    kin = kref;
    kernel_ready = 1'b1;
    chk("wload_win_ready", a_win_ready, 0);
    if (a_load_en) lcnt++;
    @(posedge clk); #1;
    kernel_ready = 1'b0;
    for (int c = 0; c < 12; c++) kin[c] = rand_vec();
    chk("load_en_cycles", lcnt, delay + 1);
    chk("load_en_after", a_load_en, 0);
    chk("run_win_ready", a_win_ready, 1);
  endtask

  task automatic drive_a(input int n, input bit gaps, input int mode);
    logic [71:0] w;
    for (int i = 0; i < n; i++) begin
      w = make_win(mode);
      win = w;
      win_valid = 1'b1;
      chk("win_ready", a_win_ready, (i < WIN_A) ? 1 : 0);
      if (i < WIN_A) exp_q.push_back('{ref_psum(w), cyc + 4});
      @(posedge clk); #1;
      if (gaps && i < WIN_A - 1) begin
        win_valid = 1'b0;
        win = make_win(0);
        @(posedge clk); #1;
      end
    end
    win_valid = 1'b0;
  endtask

  task automatic finish_a(input string tag);
    int guard;
    int n;
    guard = 0;
    while (done_a == 0 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, "_done_seen"}, done_a != 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_valid_count"}, mon_q.size(), exp_q.size());
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_psum"}, mon_q[i].psum, exp_q[i].psum);
      chk({tag, "_valid_cycle"}, mon_q[i].cyc, exp_q[i].cyc);
    end
    chk({tag, "_done_pulses"}, done_a, 1);
    chk({tag, "_done_busy"}, done_a_busy, 0);
    chk({tag, "_busy_end"}, a_busy, 0);
    chk({tag, "_valid_end"}, a_valid, 0);
    if (exp_q.size() > 0) begin
      chk({tag, "_done_cycle"}, done_a_cyc, exp_q[$].cyc + 1);
      chk({tag, "_psum_hold"}, a_psum, exp_q[$].psum);
    end
  endtask

  initial begin
    logic [239:0] cexp;
    for (int c = 0; c < 12; c++) begin
      kin[c] = rand_vec();
      kref[c] = '0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_load_en", a_load_en, 0);
    chk("rst_a_win_ready", a_win_ready, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_psum", a_psum, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_b_load_en", b_load_en, 0);
    chk("rst_b_win_ready", b_win_ready, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_psum", b_psum, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_done", b_done, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single-window run: kernels 0x01, window 0xFF
    for (int c = 0; c < 12; c++) kref[c] = {9{8'h01}};
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    chk("b_load_en", b_load_en, 1);
    chk("b_busy", b_busy, 1);
    kin = kref;
    kernel_ready = 1'b1;
    @(posedge clk); #1;
    kernel_ready = 1'b0;
    for (int c = 0; c < 12; c++) kin[c] = rand_vec();
    chk("b_win_ready_run", b_win_ready, 1);
    win = {9{8'hFF}};
    win_valid = 1'b1;
    @(posedge clk); #1;
    chk("b_win_ready_drain", b_win_ready, 0);
    @(posedge clk); #1;
    win_valid = 1'b0;
    chk("b_valid_t1", b_valid, 0);
    @(posedge clk); #1;
    chk("b_valid_t2", b_valid, 0);
    @(posedge clk); #1;
    chk("b_valid_t3", b_valid, 1);
    chk("b_psum_t3", b_psum, {12{20'h008F7}});
    chk("b_done_t3", b_done, 0);
    @(posedge clk); #1;
    chk("b_valid_t4", b_valid, 0);
    chk("b_done_t4", b_done, 1);
    chk("b_busy_t4", b_busy, 0);
    chk("b_psum_hold", b_psum, {12{20'h008F7}});
    @(posedge clk); #1;
    chk("b_done_t5", b_done, 0);

    // Random kernels, delayed ready, gapped windows, extra window held valid, kernels scrambled
    for (int c = 0; c < 12; c++) kref[c] = rand_vec();
    clear_a();
    load_a(5);
    drive_a(6, 1'b1, 0);
    finish_a("gap");

    // Most negative weights against brightest pixels
    for (int c = 0; c < 12; c++) kref[c] = {9{8'h80}};
    clear_a();
    load_a(0);
    drive_a(4, 1'b0, 1);
    finish_a("neg");
    chk("neg_const", a_psum, {12{20'hB8480}});

    // Per-channel weight c+1 against unit pixels
    for (int c = 0; c < 12; c++) kref[c] = {9{8'(c + 1)}};
    clear_a();
    load_a(1);
    drive_a(4, 1'b1, 2);
    finish_a("ramp");
    cexp = '0;
    for (int c = 0; c < 12; c++) cexp[20*c +: 20] = 20'(9 * (c + 1));
    chk("ramp_const", a_psum, cexp);

    // Reset with two windows in flight
    for (int c = 0; c < 12; c++) kref[c] = rand_vec();
    clear_a();
    load_a(2);
    drive_a(2, 1'b0, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_load_en", a_load_en, 0);
    chk("mid_rst_win_ready", a_win_ready, 0);
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_psum", a_psum, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_done", a_done, 0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_rst_no_valid", mon_q.size(), 0);
    chk("mid_rst_no_done", done_a, 0);
    chk("mid_rst_psum_after", a_psum, 0);

    // Normal run after the reset
    for (int c = 0; c < 12; c++) kref[c] = rand_vec();
    clear_a();
    load_a(1);
    drive_a(5, 1'b0, 0);
    finish_a("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
